// File: rtl/debug_snapshot_streamer.sv
// Debug snapshot streamer: live/snapshot direct-read port plus byte-serial dump
// of a frozen copy of all channels over a valid/ready byte stream.
module debug_snapshot_streamer #(
  parameter int NUM_CH = 24,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [SEL_W-1:0]         rd_sel,
  input  logic                     rd_src,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_err,
  input  logic                     snap_req,
  input  logic                     snap_abort,
  output logic                     busy,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     done
);

  localparam int BYTES = DATA_W / 8;
  localparam int WI_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] snap [NUM_CH];
  logic [WI_W-1:0]   word_idx;
  logic [BI_W-1:0]   byte_idx;
  logic              capture, advance, last_byte, last_word;
  logic              sel_ok;
  logic [DATA_W-1:0] rd_word, cur_word;
  logic [7:0]        cur_byte;

  assign capture   = (state == IDLE) && snap_req;
  assign advance   = (state == SEND) && tx_ready && !snap_abort;
  assign last_byte = (byte_idx == BI_W'(BYTES - 1));
  assign last_word = (word_idx == WI_W'(NUM_CH - 1));

  assign tx_valid = (state == SEND);
  assign busy     = (state == SEND);
  assign done     = (state == DONE);
  assign tx_data  = tx_valid ? cur_byte : 8'h00;

  // Direct-read mux; out-of-range selects leave sel_ok low.
  always_comb begin
    rd_word = '0;
    sel_ok  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        sel_ok  = 1'b1;
        rd_word = rd_src ? snap[i] : ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (word_idx == WI_W'(i)) cur_word = snap[i];
    cur_byte = 8'h00;
    for (int b = 0; b < BYTES; b++)
      if (byte_idx == BI_W'(b)) cur_byte = cur_word[b*8 +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (snap_req) state_nx = SEND;
      SEND: begin
        if (snap_abort)                          state_nx = IDLE;
        else if (tx_ready && last_byte && last_word) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_data <= sel_ok ? rd_word : '0;
      rd_err  <= !sel_ok;
      if (capture) begin
        for (int i = 0; i < NUM_CH; i++) snap[i] <= ch_data[i*DATA_W +: DATA_W];
        word_idx <= '0;
        byte_idx <= '0;
      end else if ((state == SEND) && snap_abort) begin
        word_idx <= '0;
        byte_idx <= '0;
      end else if (advance) begin
        if (last_byte) begin
          byte_idx <= '0;
          word_idx <= last_word ? '0 : word_idx + 1'b1;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

endmodule
